// File: rtl/multi_buffer_controller_if.sv
// rtl/multi_buffer_controller_if.sv - writer/reader handshake and buffer-select bundle for the frame-ownership arbiter
interface multi_buffer_controller_if #(
    parameter int NUM_BUF = 3
);
    localparam int CW = $clog2(NUM_BUF);

    logic               w_request;
    logic               r_finish;
    logic [NUM_BUF-1:0] w_buffer_id;
    logic [NUM_BUF-1:0] r_buffer_id;
    logic               w_frame_ready;
    logic               r_frame_valid;
    logic [CW-1:0]      ready_count;

    // Arbiter side: owns the buffer selects and status
    modport master (
        input  w_request,
        input  r_finish,
        output w_buffer_id,
        output r_buffer_id,
        output w_frame_ready,
        output r_frame_valid,
        output ready_count
    );

    // Writer/reader side: raises requests, consumes selects
    modport slave (
        output w_request,
        output r_finish,
        input  w_buffer_id,
        input  r_buffer_id,
        input  w_frame_ready,
        input  r_frame_valid,
        input  ready_count
    );
endinterface

// File: rtl/multi_buffer_controller.sv
// rtl/multi_buffer_controller.sv - N-buffer frame-ownership arbiter (latest/FIFO modes); MBC_STATS_EN adds drop/frame counters
module multi_buffer_controller #(
    parameter int NUM_BUF       = 3,
    parameter int MODE          = 0,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic r_clk,
    input  logic reset,
    input  logic w_clk,
    multi_buffer_controller_if.master bus
`ifdef MBC_STATS_EN
    ,
    output logic [15:0] drop_count,
    output logic [15:0] frame_count
`endif
);
    localparam int IW    = $clog2(NUM_BUF);
    localparam int QD    = NUM_BUF - 2;
    // Latest mode keeps a single READY slot; FIFO mode uses all spare buffers
    localparam int LIMIT = (MODE == 0) ? 1 : QD;
    localparam int SCW   = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_SWITCH,
        ST_WRITE_SWITCH,
        ST_SETTLE,
        ST_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      wr_idx_q, wr_idx_d;
    logic [IW-1:0]      rd_idx_q, rd_idx_d;
    logic [IW-1:0]      queue_q [QD];
    logic [IW-1:0]      queue_d [QD];
    logic [IW-1:0]      q_cnt_q, q_cnt_d;
    logic [SCW-1:0]     settle_cnt_q, settle_cnt_d;
    logic               fin_pend_q, fin_pend_d;
    logic               w_frame_ready_q, w_frame_ready_d;
    logic               r_frame_valid_q, r_frame_valid_d;
    logic [NUM_BUF-1:0] w_buffer_id_sync_q, w_buffer_id_sync_d;
    logic [NUM_BUF-1:0] r_buffer_id_q, r_buffer_id_d;
    logic               w_req_m_q, w_req_s_q;
    logic [NUM_BUF-1:0] w_id_m_q, w_id_q;
    logic [NUM_BUF-1:0] busy;
    logic [IW-1:0]      free_idx;
    logic               free_found;

    // Two-flop synchroniser for the writer's level request
    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            w_req_m_q <= 1'b0;
            w_req_s_q <= 1'b0;
        end else begin
            w_req_m_q <= bus.w_request;
            w_req_s_q <= w_req_m_q;
        end
    end

    // Ownership state, READY queue and handshake flops
    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            wr_idx_q           <= '0;
            rd_idx_q           <= IW'(1);
            for (int i = 0; i < QD; i++) begin
                queue_q[i] <= '0;
            end
            q_cnt_q            <= '0;
            settle_cnt_q       <= '0;
            fin_pend_q         <= 1'b0;
            w_frame_ready_q    <= 1'b0;
            r_frame_valid_q    <= 1'b0;
            w_buffer_id_sync_q <= NUM_BUF'(1);
            r_buffer_id_q      <= NUM_BUF'(2);
        end else begin
            state_q            <= state_d;
            wr_idx_q           <= wr_idx_d;
            rd_idx_q           <= rd_idx_d;
            queue_q            <= queue_d;
            q_cnt_q            <= q_cnt_d;
            settle_cnt_q       <= settle_cnt_d;
            fin_pend_q         <= fin_pend_d;
            w_frame_ready_q    <= w_frame_ready_d;
            r_frame_valid_q    <= r_frame_valid_d;
            w_buffer_id_sync_q <= w_buffer_id_sync_d;
            r_buffer_id_q      <= r_buffer_id_d;
        end
    end

    // Next-state: read/write switches, queue update, free-buffer pick
    always_comb begin
        state_d         = state_q;
        wr_idx_d        = wr_idx_q;
        rd_idx_d        = rd_idx_q;
        queue_d         = queue_q;
        q_cnt_d         = q_cnt_q;
        settle_cnt_d    = settle_cnt_q;
        fin_pend_d      = fin_pend_q;
        r_frame_valid_d = r_frame_valid_q;
        busy            = '0;
        free_idx        = '0;
        free_found      = 1'b0;

        // A finish seen while busy is remembered; repeats collapse into one
        if (state_q != ST_IDLE && bus.r_finish) begin
            fin_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.r_finish || fin_pend_q) begin
                    state_d    = ST_READ_SWITCH;
                    fin_pend_d = 1'b0;
                end else if (w_req_s_q) begin
                    state_d = ST_WRITE_SWITCH;
                end
            end

            ST_READ_SWITCH: begin
                if (q_cnt_q != '0) begin
                    // Old reader buffer drops out of every list, i.e. becomes FREE
                    rd_idx_d = queue_q[0];
                    for (int i = 0; i < QD - 1; i++) begin
                        queue_d[i] = queue_q[i + 1];
                    end
                    q_cnt_d         = q_cnt_q - 1'b1;
                    r_frame_valid_d = 1'b1;
                end else begin
                    // Nothing new: reader repeats its current frame
                    r_frame_valid_d = 1'b0;
                end
                state_d = ST_IDLE;
            end

            ST_WRITE_SWITCH: begin
                if (q_cnt_q == IW'(LIMIT)) begin
                    // Full: oldest READY frame is discarded, writer never stalls
                    for (int i = 0; i < LIMIT - 1; i++) begin
                        queue_d[i] = queue_q[i + 1];
                    end
                    queue_d[LIMIT - 1] = wr_idx_q;
                end else begin
                    for (int i = 0; i < QD; i++) begin
                        if (IW'(i) == q_cnt_q) begin
                            queue_d[i] = wr_idx_q;
                        end
                    end
                    q_cnt_d = q_cnt_q + 1'b1;
                end

                // Writer moves to the lowest-index buffer nobody owns
                busy[rd_idx_q] = 1'b1;
                for (int i = 0; i < QD; i++) begin
                    if (IW'(i) < q_cnt_d) begin
                        busy[queue_d[i]] = 1'b1;
                    end
                end
                for (int i = 0; i < NUM_BUF; i++) begin
                    if (!free_found && !busy[i]) begin
                        free_idx   = IW'(i);
                        free_found = 1'b1;
                    end
                end
                wr_idx_d     = free_idx;
                settle_cnt_d = SCW'(SETTLE_CYCLES);
                state_d      = ST_SETTLE;
            end

            ST_SETTLE: begin
                // Give the w_clk retiming flops time before granting
                if (settle_cnt_q <= SCW'(1)) begin
                    settle_cnt_d = '0;
                    state_d      = ST_WAIT;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end

            ST_WAIT: begin
                if (!w_req_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        w_frame_ready_d              = (state_d == ST_WAIT);
        w_buffer_id_sync_d           = '0;
        w_buffer_id_sync_d[wr_idx_d] = 1'b1;
        r_buffer_id_d                = '0;
        r_buffer_id_d[rd_idx_d]      = 1'b1;
    end

    // Retime the writer select into w_clk; unreset, valid after two w_clk edges
    always_ff @(posedge w_clk) begin
        w_id_m_q <= w_buffer_id_sync_q;
        w_id_q   <= w_id_m_q;
    end

    assign bus.w_buffer_id   = w_id_q;
    assign bus.r_buffer_id   = r_buffer_id_q;
    assign bus.w_frame_ready = w_frame_ready_q;
    assign bus.r_frame_valid = r_frame_valid_q;
    assign bus.ready_count   = q_cnt_q;

`ifdef MBC_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        drop_ev, frame_ev;

    // Saturating counts of write switches and READY frames freed unread
    always_comb begin
        frame_ev    = (state_q == ST_WRITE_SWITCH);
        drop_ev     = frame_ev && (q_cnt_q == IW'(LIMIT));
        drop_cnt_d  = drop_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (drop_ev && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (frame_ev && frame_cnt_q != 16'hFFFF) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign drop_count  = drop_cnt_q;
    assign frame_count = frame_cnt_q;
`endif
endmodule

// File: doc/multi_buffer_controller.md
Name: multi_buffer_controller

Overview:
- Parametrised N-buffer frame-ownership arbiter between one frame writer (w_clk) and one frame reader (r_clk); generalises the fixed 3-buffer ping-pong-pong scheme.
- Tracks each buffer as WRITE, READ, READY or FREE. Hands out one-hot buffer selects to the DMA writer and reader.
- Supports "latest frame" mode, which drops stale frames, and "FIFO" mode, which queues up to NUM_BUF-2 completed frames.
- Sits between the acquisition writer and the display/readout engine.

Parameters:
- NUM_BUF, 3, number of frame buffers (3..8).
- MODE, 0, 0 = latest (newest READY replaces older READY), 1 = FIFO (READY frames delivered in write order).
- SETTLE_CYCLES, 4, minimum r_clk cycles between a write switch and w_frame_ready assertion (covers w_clk retiming).

Ports:
- r_clk  in  1  control clock; all state lives here.
- reset  in  1  asynchronous, active-high.
- w_clk  in  1  writer clock; used only for the w_buffer_id retiming flops.
- w_request  in  1  writer level request for a new buffer (w_clk domain), held until w_frame_ready seen.
- r_finish  in  1  single-cycle pulse (r_clk): reader done with current buffer.
- w_buffer_id  out  NUM_BUF  one-hot writer buffer select, w_clk domain.
- r_buffer_id  out  NUM_BUF  one-hot reader buffer select, r_clk domain.
- w_frame_ready  out  1  r_clk-domain level: new writer buffer granted.
- r_frame_valid  out  1  r_buffer_id holds a completed, never-read frame.
- ready_count  out  clog2(NUM_BUF)  number of buffers in READY state.

Behaviour:
- Reset state: buffer 0 = WRITE, buffer 1 = READ, all others FREE.
- Reset outputs: w_buffer_id_sync = 0…01, r_buffer_id = 0…010, w_frame_ready = 0, r_frame_valid = 0, ready_count = 0, READY queue empty, FSM = IDLE.
- w_buffer_id = two w_clk flops of internal w_buffer_id_sync. These flops have no reset and hold X until two w_clk edges.
- w_request passes through a 2-flop r_clk synchroniser (w_req_s) before use.

FSM states and transitions:
- IDLE: r_finish → READ_SWITCH; else w_req_s → WRITE_SWITCH. r_finish has priority on a simultaneous event. An r_finish pulse arriving outside IDLE is latched into a pending flag and serviced on return to IDLE. Pulses arriving while a pending flag is set collapse into one.
- READ_SWITCH (1 cycle):
  - If the READY queue is non-empty: the reader buffer becomes FREE. The reader takes the head of the queue in MODE 1, or the sole READY buffer in MODE 0. r_frame_valid is set to 1.
  - If the queue is empty: r_buffer_id is unchanged and r_frame_valid is cleared to 0 (repeat frame).
  - Next state: IDLE.
- WRITE_SWITCH (1 cycle): the writer's buffer becomes READY and its index is pushed to the queue tail.
  - MODE 0: any previously READY buffer is returned to FREE (dropped).
  - MODE 1: if the queue already holds NUM_BUF-2 entries, the oldest entry is popped and freed (overwrite-oldest). The writer never stalls.
  - The writer takes the lowest-index FREE buffer and w_buffer_id_sync is updated. The settle counter is loaded with SETTLE_CYCLES.
  - Next state: SETTLE.
- SETTLE: counter decrements each cycle → WAIT at 0.
- WAIT: w_frame_ready = 1 (registered). Go to IDLE when w_req_s = 0; w_frame_ready is 0 from the IDLE cycle onward.

Invariants:
- Exactly one WRITE buffer and one READ buffer at all times; they never coincide.
- At least one FREE buffer exists at every WRITE_SWITCH.
- The write-switch path to READY to reader is never skipped. ready_count equals the queue occupancy (MODE 0: at most 1).

Reset mid-operation: returns to the reset state immediately and discards the queue and pending flags.

Optional Feature:
- MBC_STATS_EN defined: adds outputs drop_count[15:0] and frame_count[15:0], both in the r_clk domain and reset to 0.
  - drop_count increments once per READY buffer freed without having been read.
  - frame_count increments once per WRITE_SWITCH.
  - Both counters saturate at 16'hFFFF.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- NUM_BUF=3, MODE=0; after reset, pulse w_request → w_frame_ready rises 2+1+SETTLE_CYCLES+1 r_clk later. Check w_buffer_id_sync = 3'b100 and ready_count = 1. Drop w_request → w_frame_ready falls.
- Continuing: r_finish pulse → r_buffer_id = 3'b001, r_frame_valid = 1, ready_count = 0. A second r_finish with nothing READY → r_buffer_id stays 3'b001, r_frame_valid = 0.
- NUM_BUF=5, MODE=1: three write handshakes with no reads → ready_count = 3 and the queue holds indices 0, 2, 3 in order. Three r_finish pulses → r_buffer_id visits 5'b00001, 5'b00100, 5'b01000.
- NUM_BUF=4, MODE=1, MBC_STATS_EN: four writes without reads → ready_count = 2, drop_count = 2, frame_count = 4. Check the one-WRITE/one-READ invariant every cycle.
- Assert r_finish and w_request in the same IDLE cycle → READ_SWITCH first, then WRITE_SWITCH two cycles later. Pulse r_finish during WAIT → serviced on the first IDLE cycle.
- Assert reset while in SETTLE → all outputs return to reset values within one cycle of reset assertion (asynchronous). Check that no X appears on r_clk-domain outputs.
